// File: rtl/app_stat_pkg.sv
// -----------------------------------------------------------------------------
// app_stat_pkg
//   Shared register map, CTRL bit positions, per-channel block layout and
//   small helpers for the app_stat_csr statistics block.
// -----------------------------------------------------------------------------
package app_stat_pkg;

  // Global registers (byte offsets from BASE_ADDR)
  localparam logic [31:0] OFF_APP_TYPE = 32'h0000_0000;
  localparam logic [31:0] OFF_APP_VER  = 32'h0000_0004;
  localparam logic [31:0] OFF_CHANNELS = 32'h0000_0008;
  localparam logic [31:0] OFF_SCRATCH  = 32'h0000_000C;
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0010;
  localparam logic [31:0] OFF_CH_EN    = 32'h0000_0014;

  // CTRL write-one pulse bits
  localparam int unsigned CTRL_SNAP_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT  = 1;

  // Per-channel block: CH_BASE + n*CH_STRIDE
  localparam logic [31:0] CH_BASE    = 32'h0000_0100;
  localparam logic [31:0] CH_STRIDE  = 32'h0000_0020;
  localparam int unsigned CH_SHIFT   = 5;
  localparam logic [31:0] CH_PKT_LO  = 32'h0000_0000;
  localparam logic [31:0] CH_PKT_HI  = 32'h0000_0004;
  localparam logic [31:0] CH_BYTE_LO = 32'h0000_0008;
  localparam logic [31:0] CH_BYTE_HI = 32'h0000_000C;

  // Decoded register access: hit = inside the block's window,
  // off = word-aligned byte offset from the base.
  typedef struct packed {
    logic        hit;
    logic [31:0] off;
  } win_dec_t;

  function automatic win_dec_t win_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    win_dec_t r;
    logic [31:0] diff;
    diff  = addr - base;
    r.hit = (addr >= base) && (diff < size);
    r.off = {diff[31:2], 2'b00};
    return r;
  endfunction

  // Byte-lane merge of a 32-bit write into an existing value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/app_keep_popcnt.sv
// -----------------------------------------------------------------------------
// app_keep_popcnt
//   Combinational population count of one channel's tkeep.
//   keep_i : tkeep bits of one channel
//   cnt_o  : number of set bits (0..KEEP_WIDTH)
// -----------------------------------------------------------------------------
module app_keep_popcnt #(
  parameter int unsigned KEEP_WIDTH = 64
) (
  input  logic [KEEP_WIDTH-1:0]         keep_i,
  output logic [$clog2(KEEP_WIDTH+1)-1:0] cnt_o
);

  localparam int unsigned CW = $clog2(KEEP_WIDTH+1);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      cnt_o = cnt_o + CW'(keep_i[i]);
  end

endmodule

// File: rtl/app_stat_csr.sv
// -----------------------------------------------------------------------------
// app_stat_csr
//   Per-channel AXI-stream packet/byte statistics with a simple register port.
//   Live counters run continuously; SNAP copies them to shadows (what the bus
//   reads), CLR zeroes the live set.
//
//   clk, rst                 : clock, synchronous active-high reset
//   mon_tkeep/tvalid/tready/
//   mon_tlast                : monitored stream taps, channel n at lane n
//   ch_en                    : per-channel enable mask (RW register)
//   reg_wr_* / reg_rd_*      : register write/read ports; one-cycle ack,
//                              read data zero when not acked (OR-able bus)
// -----------------------------------------------------------------------------
module app_stat_csr
  import app_stat_pkg::*;
#(
  parameter int unsigned               CHANNELS       = 4,
  parameter int unsigned               KEEP_WIDTH     = 64,
  parameter int unsigned               CNT_WIDTH      = 64,
  parameter int unsigned               REG_ADDR_WIDTH = 16,
  parameter int unsigned               REG_DATA_WIDTH = 32,
  parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0000,
  parameter logic [31:0]               APP_TYPE       = 32'h0102_0304,
  parameter logic [31:0]               APP_VER        = 32'h0000_0200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] mon_tkeep,
  input  logic [CHANNELS-1:0]            mon_tvalid,
  input  logic [CHANNELS-1:0]            mon_tready,
  input  logic [CHANNELS-1:0]            mon_tlast,
  output logic [CHANNELS-1:0]            ch_en,
  input  logic [REG_ADDR_WIDTH-1:0]      reg_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0]      reg_wr_data,
  input  logic [3:0]                     reg_wr_strb,
  input  logic                           reg_wr_en,
  output logic                           reg_wr_wait,
  output logic                           reg_wr_ack,
  input  logic [REG_ADDR_WIDTH-1:0]      reg_rd_addr,
  input  logic                           reg_rd_en,
  output logic                           reg_rd_wait,
  output logic                           reg_rd_ack,
  output logic [REG_DATA_WIDTH-1:0]      reg_rd_data
);

  if (REG_DATA_WIDTH != 32) begin : g_bad_dw
    $error("app_stat_csr: REG_DATA_WIDTH must be 32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("app_stat_csr: CHANNELS must be 1..16");
  end
  if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cw
    $error("app_stat_csr: CNT_WIDTH must be 8..64");
  end

  localparam int unsigned PCW      = $clog2(KEEP_WIDTH+1);
  localparam logic [31:0] WIN_SIZE = CH_BASE + 32'(CHANNELS) * CH_STRIDE;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  win_dec_t wr_dec, rd_dec;
  assign wr_dec = win_decode(32'(reg_wr_addr), 32'(BASE_ADDR), WIN_SIZE);
  assign rd_dec = win_decode(32'(reg_rd_addr), 32'(BASE_ADDR), WIN_SIZE);

  logic wr_ack_q, rd_ack_q;
  logic wr_fire, rd_fire;
  // The !ack term gives a single ack per request even if en is held.
  assign wr_fire = reg_wr_en && wr_dec.hit && !wr_ack_q;
  assign rd_fire = reg_rd_en && rd_dec.hit && !rd_ack_q;

  logic snap, clr;
  assign snap = wr_fire && (wr_dec.off == OFF_CTRL) && reg_wr_data[CTRL_SNAP_BIT];
  assign clr  = wr_fire && (wr_dec.off == OFF_CTRL) && reg_wr_data[CTRL_CLR_BIT];

  // ---------------------------------------------------------------------------
  // RW registers
  // ---------------------------------------------------------------------------
  logic [31:0]         scratch_q, scratch_d;
  logic [CHANNELS-1:0] ch_en_q, ch_en_d;

  always_comb begin
    scratch_d = scratch_q;
    ch_en_d   = ch_en_q;
    if (wr_fire) begin
      case (wr_dec.off)
        OFF_SCRATCH: scratch_d = strb_merge(scratch_q, reg_wr_data, reg_wr_strb);
        // Bits above CHANNELS fall off in the narrowing cast.
        OFF_CH_EN:   ch_en_d   = CHANNELS'(strb_merge(32'(ch_en_q), reg_wr_data, reg_wr_strb));
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel live counters and shadows
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] pkt_q, pkt_d, byte_q, byte_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] pkt_sh_q, byte_sh_q;
  logic [CHANNELS-1:0][63:0]          pkt_x, byte_x;
  logic [CHANNELS-1:0]                beat;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [PCW-1:0] keep_cnt;

    app_keep_popcnt #(.KEEP_WIDTH(KEEP_WIDTH)) u_popcnt (
      .keep_i (mon_tkeep[n*KEEP_WIDTH +: KEEP_WIDTH]),
      .cnt_o  (keep_cnt)
    );

    assign beat[n] = mon_tvalid[n] & mon_tready[n];
    // CLR wins over a coincident beat so the counter reads exactly zero.
    assign pkt_d[n]  = clr ? '0 : pkt_q[n] + CNT_WIDTH'(beat[n] & mon_tlast[n]);
    assign byte_d[n] = clr ? '0 : byte_q[n] + (beat[n] ? CNT_WIDTH'(keep_cnt) : '0);

    assign pkt_x[n]  = 64'(pkt_sh_q[n]);
    assign byte_x[n] = 64'(byte_sh_q[n]);
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word, ch_off, ch_sel;

  always_comb begin
    rd_word = '0;
    ch_off  = rd_dec.off - CH_BASE;
    ch_sel  = ch_off >> CH_SHIFT;
    case (rd_dec.off)
      OFF_APP_TYPE: rd_word = APP_TYPE;
      OFF_APP_VER:  rd_word = APP_VER;
      OFF_CHANNELS: rd_word = 32'(CHANNELS);
      OFF_SCRATCH:  rd_word = scratch_q;
      OFF_CH_EN:    rd_word = 32'(ch_en_q);
      default: ;
    endcase
    if (rd_dec.off >= CH_BASE) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_sel == 32'(n)) begin
          case (ch_off & (CH_STRIDE - 32'd1))
            CH_PKT_LO:  rd_word = pkt_x[n][31:0];
            CH_PKT_HI:  rd_word = pkt_x[n][63:32];
            CH_BYTE_LO: rd_word = byte_x[n][31:0];
            CH_BYTE_HI: rd_word = byte_x[n][63:32];
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      scratch_q <= '0;
      ch_en_q   <= '1;
      pkt_q     <= '0;
      byte_q    <= '0;
      pkt_sh_q  <= '0;
      byte_sh_q <= '0;
    end else begin
      wr_ack_q  <= wr_fire;
      rd_ack_q  <= rd_fire;
      rd_data_q <= rd_fire ? rd_word : '0;
      scratch_q <= scratch_d;
      ch_en_q   <= ch_en_d;
      pkt_q     <= pkt_d;
      byte_q    <= byte_d;
      // Shadows take the register values, i.e. before any same-edge CLR.
      if (snap) begin
        pkt_sh_q  <= pkt_q;
        byte_sh_q <= byte_q;
      end
    end
  end

  assign ch_en       = ch_en_q;
  assign reg_wr_ack  = wr_ack_q;
  assign reg_rd_ack  = rd_ack_q;
  assign reg_rd_data = rd_data_q;
  assign reg_wr_wait = 1'b0;
  assign reg_rd_wait = 1'b0;

endmodule

// File: tb/tb_app_stat_csr.sv
module tb_app_stat_csr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] mon_tkeep = '0;
  logic [3:0]   mon_tvalid = '0, mon_tready = '0, mon_tlast = '0;
  logic [15:0]  reg_wr_addr = '0, reg_rd_addr = '0;
  logic [31:0]  reg_wr_data = '0;
  logic [3:0]   reg_wr_strb = '0;
  logic         reg_wr_en = 1'b0, reg_rd_en = 1'b0;

  // a_: default parameters, b_: CNT_WIDTH=8 for wrap checks (shared inputs)
  logic [3:0]  a_ch_en, b_ch_en;
  logic        a_wr_wait, a_wr_ack, a_rd_wait, a_rd_ack;
  logic        b_wr_wait, b_wr_ack, b_rd_wait, b_rd_ack;
  logic [31:0] a_rd_data, b_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  app_stat_csr dut_a (
    .clk(clk), .rst(rst), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .ch_en(a_ch_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(a_wr_wait), .reg_wr_ack(a_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_wait(a_rd_wait),
    .reg_rd_ack(a_rd_ack), .reg_rd_data(a_rd_data)
  );

  app_stat_csr #(.CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .ch_en(b_ch_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(b_wr_wait), .reg_wr_ack(b_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_wait(b_rd_wait),
    .reg_rd_ack(b_rd_ack), .reg_rd_data(b_rd_data)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called and returning at posedge+1. leak flags nonzero data while ack low.
  task automatic do_read(input logic [15:0] a, output logic ack, output int lat,
                         output logic [31:0] da, output logic [31:0] db, output logic leak);
    reg_rd_addr = a; reg_rd_en = 1'b1;
    ack = 1'b0; lat = 0; da = '0; db = '0; leak = 1'b0;
    for (int i = 1; i <= 4 && !ack; i++) begin
      @(posedge clk); #1;
      if (a_rd_ack) begin ack = 1'b1; lat = i; da = a_rd_data; db = b_rd_data; end
      else if (a_rd_data != 0) leak = 1'b1;
    end
    reg_rd_en = 1'b0;
    @(posedge clk); #1;
    if (a_rd_ack || a_rd_data != 0) leak = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic ack, output int lat);
    reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
    ack = 1'b0; lat = 0;
    for (int i = 1; i <= 4 && !ack; i++) begin
      @(posedge clk); #1;
      if (a_wr_ack) begin ack = 1'b1; lat = i; end
    end
    reg_wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string name, input logic [15:0] a, input logic [31:0] d);
    logic ack; int lat;
    do_write(a, d, 4'hF, ack, lat);
    chk({name, "_ack"}, 32'(ack), 32'd1);
  endtask

  // Read on dut_a (sel=0) or dut_b (sel=1) and compare.
  task automatic rd(input string name, input bit sel, input logic [15:0] a, input logic [31:0] exp);
    logic ack, leak; int lat; logic [31:0] da, db;
    do_read(a, ack, lat, da, db, leak);
    chk({name, "_ack"}, 32'(ack), 32'd1);
    chk(name, sel ? db : da, exp);
  endtask

  task automatic beat(input int ch, input logic [63:0] keep, input logic last,
                      input logic valid, input logic ready);
    mon_tkeep = '0;
    mon_tkeep[ch*64 +: 64] = keep;
    mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    mon_tvalid[ch] = valid; mon_tready[ch] = ready; mon_tlast[ch] = last;
    @(posedge clk); #1;
    mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
  endtask

  initial begin
    logic ack, leak; int lat; logic [31:0] da, db;

    vecs[0]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 1'b1, 32'h0102_0304};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 1'b1, 32'h0000_0200};
    vecs[2]  = '{1'b0, 16'h0008, 32'h0,         4'h0, 1'b1, 32'h0000_0004};
    vecs[3]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 16'h0014, 32'h0,         4'h0, 1'b1, 32'h0000_000F};
    vecs[5]  = '{1'b1, 16'h000C, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
    vecs[7]  = '{1'b1, 16'h0014, 32'hFFFF_FFF5, 4'h1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 16'h0014, 32'h0,         4'h0, 1'b1, 32'h0000_0005};
    vecs[9]  = '{1'b0, 16'h0010, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b1, 16'h0018, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 16'h0018, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[12] = '{1'b0, 16'h017C, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 16'h0180, 32'h0,         4'h0, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b0, 16'h0F00, 32'h0,         4'h0, 1'b0, 32'h0000_0000};
    vecs[15] = '{1'b0, 16'h0104, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[16] = '{1'b1, 16'h0F00, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 16'h000C, 32'h0,         4'h0, 1'b1, 32'h00BB_00DD};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wr_ack",  32'(a_wr_ack), 32'd0);
    chk("rst_rd_ack",  32'(a_rd_ack), 32'd0);
    chk("rst_rd_data", a_rd_data, 32'd0);
    chk("rst_ch_en",   32'(a_ch_en), 32'hF);
    chk("wait_tied",   32'({a_wr_wait, a_rd_wait, b_wr_wait, b_rd_wait}), 32'd0);

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, ack, lat);
        chk($sformatf("vec%0d_wack", i), 32'(ack), 32'(vecs[i].exp_ack));
        if (ack) chk($sformatf("vec%0d_wlat", i), 32'(lat), 32'd1);
      end else begin
        do_read(vecs[i].addr, ack, lat, da, db, leak);
        chk($sformatf("vec%0d_rack", i), 32'(ack), 32'(vecs[i].exp_ack));
        chk($sformatf("vec%0d_rdata", i), da, vecs[i].exp_data);
        chk($sformatf("vec%0d_leak", i), 32'(leak), 32'd0);
        if (ack) chk($sformatf("vec%0d_rlat", i), 32'(lat), 32'd1);
      end
    end
    chk("ch_en_out", 32'(a_ch_en), 32'h5);

    // Counting: ch1 sends 3 x 100 B packets (64 + 36), plus non-beats
    for (int p = 0; p < 3; p++) begin
      beat(1, {64{1'b1}}, 1'b0, 1'b1, 1'b1);
      beat(1, 64'h0000_000F_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    end
    beat(1, {64{1'b1}}, 1'b1, 1'b1, 1'b0);
    beat(1, {64{1'b1}}, 1'b1, 1'b0, 1'b1);
    wr("snap1", 16'h0010, 32'h1);
    rd("ch1_pkt_lo",  0, 16'h0120, 32'd3);
    rd("ch1_pkt_hi",  0, 16'h0124, 32'd0);
    rd("ch1_byte_lo", 0, 16'h0128, 32'd300);
    rd("ch1_byte_hi", 0, 16'h012C, 32'd0);
    rd("ch0_pkt_lo",  0, 16'h0100, 32'd0);
    rd("ch2_byte_lo", 0, 16'h0148, 32'd0);
    rd("ch3_pkt_lo",  0, 16'h0160, 32'd0);

    // CLR collides with a tlast beat on ch0
    beat(0, 64'hF, 1'b1, 1'b1, 1'b1);
    beat(0, 64'hF, 1'b1, 1'b1, 1'b1);
    reg_wr_addr = 16'h0010; reg_wr_data = 32'h2; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    mon_tkeep = '0; mon_tkeep[63:0] = 64'hFF;
    mon_tvalid = 4'b0001; mon_tready = 4'b0001; mon_tlast = 4'b0001;
    @(posedge clk); #1;
    chk("clr_ack", 32'(a_wr_ack), 32'd1);
    reg_wr_en = 1'b0;
    mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    @(posedge clk); #1;
    rd("clr_keeps_shadow", 0, 16'h0120, 32'd3);
    wr("snap2", 16'h0010, 32'h1);
    rd("clr_ch0_pkt",  0, 16'h0100, 32'd0);
    rd("clr_ch0_byte", 0, 16'h0108, 32'd0);
    rd("clr_ch1_pkt",  0, 16'h0120, 32'd0);

    // SNAP and CLR together: shadow gets pre-clear value
    beat(2, 64'hFF, 1'b1, 1'b1, 1'b1);
    beat(2, 64'hFF, 1'b1, 1'b1, 1'b1);
    wr("snapclr", 16'h0010, 32'h3);
    rd("sc_ch2_pkt",  0, 16'h0140, 32'd2);
    rd("sc_ch2_byte", 0, 16'h0148, 32'd16);
    wr("snap3", 16'h0010, 32'h1);
    rd("sc_ch2_cleared", 0, 16'h0140, 32'd0);

    // Wrap: 257 single-beat 1-byte packets on ch0
    for (int k = 0; k < 257; k++) beat(0, 64'h1, 1'b1, 1'b1, 1'b1);
    wr("snap4", 16'h0010, 32'h1);
    rd("w8_pkt_lo",  1, 16'h0100, 32'd1);
    rd("w8_pkt_hi",  1, 16'h0104, 32'd0);
    rd("w8_byte_lo", 1, 16'h0108, 32'd1);
    rd("w64_pkt_lo", 0, 16'h0100, 32'd257);

    // Reset mid-read, with beats present on ch3
    reg_rd_addr = 16'h0000; reg_rd_en = 1'b1; rst = 1'b1;
    mon_tkeep = '0; mon_tkeep[255:192] = 64'hFF;
    mon_tvalid = 4'b1000; mon_tready = 4'b1000; mon_tlast = 4'b1000;
    @(posedge clk); #1;
    chk("rst_mid_ack",  32'(a_rd_ack), 32'd0);
    chk("rst_mid_data", a_rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; reg_rd_en = 1'b0;
    mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    chk("rst_mid_ack2", 32'(a_rd_ack), 32'd0);
    chk("rst_ch_en_a", 32'(a_ch_en), 32'hF);
    chk("rst_ch_en_b", 32'(b_ch_en), 32'hF);
    rd("rst_scratch", 0, 16'h000C, 32'd0);
    rd("rst_shadow",  0, 16'h0100, 32'd0);
    wr("snap5", 16'h0010, 32'h1);
    rd("rst_no_count", 0, 16'h0160, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/app_stat_csr.md
APP_STAT_CSR -- requirements
Module: app_stat_csr

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of monitored AXI-stream channels, 1..16.
REQ-002 SHALL have parameter KEEP_WIDTH, default 64: tkeep bits per channel.
REQ-003 SHALL have parameter CNT_WIDTH, default 64: packet/byte counter width, 8..64.
REQ-004 SHALL have parameter REG_ADDR_WIDTH, default 16, and REG_DATA_WIDTH, fixed 32 (any other value is an elaboration error).
REQ-005 SHALL have parameters BASE_ADDR (default 16'h0000), APP_TYPE (default 32'h0102_0304) and APP_VER (default 32'h0000_0200).
REQ-006 SHALL have clk, input, 1: clock.
REQ-007 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have mon_tkeep, input, CHANNELS*KEEP_WIDTH: per-channel tkeep, channel n at bits [n*KEEP_WIDTH +: KEEP_WIDTH].
REQ-009 SHALL have mon_tvalid, mon_tready and mon_tlast, each input, CHANNELS: per-channel handshake and last flags.
REQ-010 SHALL have ch_en, output, CHANNELS: per-channel enable mask for external gating.
REQ-011 SHALL have reg_wr_addr (REG_ADDR_WIDTH), reg_wr_data (32), reg_wr_strb (4), reg_wr_en (1) and reg_rd_addr (REG_ADDR_WIDTH), reg_rd_en (1), all input.
REQ-012 SHALL have reg_wr_wait, reg_wr_ack, reg_rd_wait, reg_rd_ack (1 each) and reg_rd_data (32), all output.

Function
REQ-013 SHALL use this map, offsets from BASE_ADDR: 0x00 APP_TYPE RO; 0x04 APP_VER RO; 0x08 CHANNELS RO; 0x0C scratch RW; 0x10 CTRL; 0x14 ch_en RW.
REQ-014 SHALL define CTRL write bits: bit0 SNAP and bit1 CLR, both write-one self-clearing; CTRL reads as 0.
REQ-015 SHALL place the per-channel block at 0x100 + n*0x20: +0x00 pkt_lo, +0x04 pkt_hi, +0x08 byte_lo, +0x0C byte_hi; all RO, returning snapshot values, zero-extended above CNT_WIDTH.
REQ-016 SHALL count a beat on channel n only when mon_tvalid[n] and mon_tready[n] are both high.
REQ-017 SHALL add popcount(tkeep[n]) to the byte counter on every beat, and add 1 to the packet counter on every beat with tlast[n] high.
REQ-018 SHALL wrap counters modulo 2^CNT_WIDTH without saturating or flagging.
REQ-019 SHALL, on SNAP, copy all live counters of all channels into the shadow registers in the same clock edge as the write ack.
REQ-020 SHALL, on CLR, zero all live counters; shadows are unchanged.
REQ-021 SHALL, when SNAP and CLR are written together, give shadows the pre-clear values.
REQ-022 SHALL discard a beat that coincides with the CLR edge, so the counter reads 0 afterwards.
REQ-023 SHALL apply reg_wr_strb per byte to scratch and ch_en; unmapped ch_en bits are ignored.
REQ-024 SHALL, for an in-window address with en high and ack low, assert ack for exactly one cycle on the next edge.
REQ-025 SHALL present read data with ack; reg_rd_data SHALL be 0 whenever reg_rd_ack is low, so the bus is OR-combinable.
REQ-026 SHALL treat addresses BASE_ADDR..BASE_ADDR+0x100+CHANNELS*0x20-1 as the window; unmapped holes in the window ack with data 0 and writes to them are ignored.
REQ-027 SHALL NOT ack out-of-window addresses, and reg_rd_data SHALL stay 0 for them.
REQ-028 SHALL tie reg_wr_wait and reg_rd_wait to 0.
REQ-029 SHALL make a register write visible to reads and to ch_en in the cycle after ack.

Reset
REQ-030 SHALL reset to: ack outputs 0, reg_rd_data 0, scratch 0, ch_en all ones, live counters 0, shadows 0.
REQ-031 SHALL abort an in-flight access when rst is asserted, with no ack issued.
REQ-032 SHALL count no beats during reset.

Structure
REQ-033 SHALL place register offsets, the CTRL bit positions and the per-channel stride in the shared package app_stat_pkg.
REQ-034 SHALL implement per-channel keep popcount in one sub-module, app_keep_popcnt: combinational, KEEP_WIDTH parameter, output width $clog2(KEEP_WIDTH+1).

Verification
REQ-035 SHALL test ID reads: read 0x00/0x04/0x08 -> 0x01020304, 0x00000200, 4, each acked 1 cycle after en.
REQ-036 SHALL test scratch strobes: write 0xAABBCCDD with strb 0101 to a zeroed scratch -> reads 0x00BB00DD.
REQ-037 SHALL test counting: ch1 sends 3 packets of 100 B (beats of keep 64 + 36 bytes), then SNAP -> pkt_lo 3, byte_lo 300, other channels 0.
REQ-038 SHALL test CLR collision: CLR ack coincides with a tlast beat on ch0, then SNAP -> ch0 pkt_lo 0.
REQ-039 SHALL test wrap: with CNT_WIDTH=8, 257 single-beat 1-byte packets, then SNAP -> pkt_lo 1, pkt_hi 0.
REQ-040 SHALL test window and reset: read 0x0F00 with CHANNELS=4 -> no ack, data 0; assert rst mid-read -> no ack, ch_en 0xF.
